legv8_mem_port: RTL and testbench

- Parametrised load/store port between the LEGv8 datapath/control unit and system memory.
- Replaces the raw 64-bit inout data bus plus bare address with a valid/ready request/response handshake.
- Supports byte, half, word and double access sizes, lane alignment with byte enables, sign/zero extension, misalignment detection and a bus timeout.
- Sits between the CPU core and the memory/bus fabric, one instance per core.

---
 rtl/legv8_mem_pkg.sv | 24 ++
 rtl/legv8_lane_align.sv | 50 +++++
 rtl/legv8_mem_port.sv | 174 +++++++++++++++++
 tb/tb_legv8_mem_port.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/legv8_mem_pkg.sv
// rtl/legv8_mem_pkg.sv - shared encodings, state enum and size helper for the LEGv8 memory port
package legv8_mem_pkg;

  localparam logic [1:0] SZ_BYTE   = 2'b00;
  localparam logic [1:0] SZ_HALF   = 2'b01;
  localparam logic [1:0] SZ_WORD   = 2'b10;
  localparam logic [1:0] SZ_DOUBLE = 2'b11;

  localparam logic [1:0] FLT_NONE    = 2'b00;
  localparam logic [1:0] FLT_ALIGN   = 2'b01;
  localparam logic [1:0] FLT_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_t;

  // Number of bytes moved by an access of the given size encoding.
  function automatic logic [3:0] size_bytes(input logic [1:0] sz);
    return 4'd1 << sz;
  endfunction

endpackage

// File: rtl/legv8_lane_align.sv
// rtl/legv8_lane_align.sv - combinational byte-lane steering for stores and extract/extend for loads
module legv8_lane_align #(
  parameter int DATA_WIDTH = 64,
  localparam int BE_W      = DATA_WIDTH / 8,
  localparam int OFF_W     = $clog2(BE_W)
) (
  input  logic [1:0]            i_size,
  input  logic                  i_signed,
  input  logic [OFF_W-1:0]      i_off,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  output logic [BE_W-1:0]       o_be,
  output logic [DATA_WIDTH-1:0] o_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);
  import legv8_mem_pkg::*;

  logic [DATA_WIDTH-1:0] w_shift;
  logic                  w_msb;
  logic                  w_fill;
  int                    w_nbytes;

  assign o_wdata = i_wdata << {i_off, 3'b000};

  // Byte enables cover the accessed bytes starting at the lane offset; load data is
  // shifted down, truncated to the access size and extended with the sign or zero.
  always_comb begin
    w_nbytes = int'(size_bytes(i_size));
    w_shift  = i_rdata >> {i_off, 3'b000};
    o_be     = '0;
    for (int b = 0; b < BE_W; b++) begin
      o_be[b] = (b >= int'(i_off)) && (b < int'(i_off) + w_nbytes);
    end
    case (i_size)
      SZ_BYTE: w_msb = w_shift[7];
      SZ_HALF: w_msb = w_shift[15];
      SZ_WORD: w_msb = w_shift[31];
      default: w_msb = w_shift[DATA_WIDTH-1];
    endcase
    w_fill  = i_signed & w_msb;
    o_rdata = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      o_rdata[i] = (i < 8 * w_nbytes) ? w_shift[i] : w_fill;
    end
    if (i_size == SZ_DOUBLE) begin
      o_rdata = i_rdata;
    end
  end

endmodule

// File: rtl/legv8_mem_port.sv
// rtl/legv8_mem_port.sv - LEGv8 load/store port with request/response handshake; stats via LEGV8_MEM_PORT_STATS_EN
module legv8_mem_port #(
  parameter int DATA_WIDTH     = 64,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [1:0]              req_size,
  input  logic                    req_signed,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_fault,
  output logic                    mem_valid,
  input  logic                    mem_ready,
  output logic                    mem_write,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
`ifdef LEGV8_MEM_PORT_STATS_EN
  output logic [31:0]             stat_loads,
  output logic [31:0]             stat_stores,
  output logic [31:0]             stat_faults,
`endif
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);
  import legv8_mem_pkg::*;

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                r_state;
  state_t                w_next;
  logic                  r_write;
  logic                  r_signed;
  logic [1:0]            r_size;
  logic [1:0]            r_fault;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [CNT_W-1:0]      r_cnt;

  logic                  w_legal;
  logic                  w_access;
  logic [BE_W-1:0]       w_be;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_access = (r_state == ST_ACCESS);

  // A request is legal when the size fits the bus and the address is naturally aligned.
  always_comb begin
    w_legal = 1'b0;
    case (req_size)
      SZ_BYTE: w_legal = 1'b1;
      SZ_HALF: w_legal = (req_addr[0] == 1'b0);
      SZ_WORD: w_legal = (req_addr[1:0] == 2'b00);
      default: w_legal = (DATA_WIDTH == 64) && (req_addr[2:0] == 3'b000);
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next state: illegal requests skip the memory cycle; mem_ready beats the timeout.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (req_valid) w_next = w_legal ? ST_ACCESS : ST_RESP;
      ST_ACCESS: if (mem_ready || (r_cnt == CNT_LAST)) w_next = ST_RESP;
      ST_RESP:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Capture the request, count wait cycles and latch the response.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_write  <= 1'b0;
      r_signed <= 1'b0;
      r_size   <= SZ_BYTE;
      r_fault  <= FLT_NONE;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (req_valid) begin
          r_write  <= req_write;
          r_signed <= req_signed;
          r_size   <= req_size;
          r_addr   <= req_addr;
          r_wdata  <= req_wdata;
          r_rdata  <= '0;
          r_cnt    <= '0;
          r_fault  <= w_legal ? FLT_NONE : FLT_ALIGN;
        end
        ST_ACCESS: begin
          if (mem_ready) begin
            r_fault <= FLT_NONE;
            r_rdata <= r_write ? '0 : w_rdata;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_fault <= FLT_TIMEOUT;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  legv8_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
    .i_size   (r_size),
    .i_signed (r_signed),
    .i_off    (r_addr[OFF_W-1:0]),
    .i_wdata  (r_wdata),
    .i_rdata  (mem_rdata),
    .o_be     (w_be),
    .o_wdata  (w_wdata),
    .o_rdata  (w_rdata)
  );

  assign req_ready = (r_state == ST_IDLE);
  assign mem_valid = w_access;
  assign mem_write = w_access & r_write;
  assign mem_addr  = w_access ? {r_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign mem_be    = w_access ? w_be : '0;
  assign mem_wdata = w_access ? w_wdata : '0;
  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_rdata = rsp_valid ? r_rdata : '0;
  assign rsp_fault = rsp_valid ? r_fault : FLT_NONE;

`ifdef LEGV8_MEM_PORT_STATS_EN
  logic [31:0] r_stat_loads;
  logic [31:0] r_stat_stores;
  logic [31:0] r_stat_faults;

  // Saturating counters of completed loads, stores and faulted requests.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_stat_loads  <= '0;
      r_stat_stores <= '0;
      r_stat_faults <= '0;
    end else if (r_state == ST_RESP) begin
      if (r_fault != FLT_NONE) begin
        if (r_stat_faults != '1) r_stat_faults <= r_stat_faults + 32'd1;
      end else if (r_write) begin
        if (r_stat_stores != '1) r_stat_stores <= r_stat_stores + 32'd1;
      end else begin
        if (r_stat_loads != '1) r_stat_loads <= r_stat_loads + 32'd1;
      end
    end
  end

  assign stat_loads  = r_stat_loads;
  assign stat_stores = r_stat_stores;
  assign stat_faults = r_stat_faults;
`endif

endmodule

// File: tb/tb_legv8_mem_port.sv
// tb/tb_legv8_mem_port.sv - randomized self-checking bench for legv8_mem_port against a lane-arithmetic model
module tb_legv8_mem_port;
  import legv8_mem_pkg::*;

  localparam int TO = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size, rsp_fault;
  logic [31:0] req_addr, mem_addr;
  logic [63:0] req_wdata, rsp_rdata, mem_wdata, mem_rdata;
  logic        rsp_valid, mem_valid, mem_ready, mem_write;
  logic [7:0]  mem_be;

  logic        req_valid_n, req_ready_n, req_write_n, req_signed_n;
  logic [1:0]  req_size_n, rsp_fault_n;
  logic [31:0] req_addr_n, mem_addr_n;
  logic [31:0] req_wdata_n, rsp_rdata_n, mem_wdata_n, mem_rdata_n;
  logic        rsp_valid_n, mem_valid_n, mem_ready_n, mem_write_n;
  logic [3:0]  mem_be_n;

`ifdef LEGV8_MEM_PORT_STATS_EN
  logic [31:0] stat_loads, stat_stores, stat_faults;
  logic [31:0] stat_loads_n, stat_stores_n, stat_faults_n;
`endif

  legv8_mem_port #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_fault(rsp_fault), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata),
`ifdef LEGV8_MEM_PORT_STATS_EN
    .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_faults(stat_faults),
`endif
    .mem_rdata(mem_rdata)
  );

  legv8_mem_port #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut32 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid_n), .req_ready(req_ready_n), .req_write(req_write_n),
    .req_size(req_size_n), .req_signed(req_signed_n), .req_addr(req_addr_n),
    .req_wdata(req_wdata_n), .rsp_valid(rsp_valid_n), .rsp_rdata(rsp_rdata_n),
    .rsp_fault(rsp_fault_n), .mem_valid(mem_valid_n), .mem_ready(mem_ready_n),
    .mem_write(mem_write_n), .mem_addr(mem_addr_n), .mem_be(mem_be_n),
    .mem_wdata(mem_wdata_n),
`ifdef LEGV8_MEM_PORT_STATS_EN
    .stat_loads(stat_loads_n), .stat_stores(stat_stores_n), .stat_faults(stat_faults_n),
`endif
    .mem_rdata(mem_rdata_n)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int exp_loads = 0, exp_stores = 0, exp_faults = 0;
  logic [63:0] last_rdata;
  logic [1:0]  last_fault;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: natural alignment, byte-offset arithmetic and masked extension.
  function automatic void model(input int dwb, input logic [1:0] sz, input logic sg,
                                input logic [31:0] addr, input logic [63:0] wd, input logic [63:0] rd,
                                output logic legal, output logic [7:0] be, output logic [63:0] wdx,
                                output logic [63:0] rdx, output logic [31:0] maddr);
    int nb, off;
    logic [63:0] mask, dmask, v;
    nb    = 1 << sz;
    off   = int'(addr % dwb);
    legal = (nb <= dwb) && ((addr % nb) == 0);
    maddr = addr - off;
    be    = 8'(((1 << nb) - 1) << off);
    dmask = (dwb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    wdx   = (wd << (8 * off)) & dmask;
    mask  = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
    v     = (rd >> (8 * off)) & mask;
    if (sg && v[8 * nb - 1]) v = v | ~mask;
    rdx   = v & dmask;
  endfunction

  // One request on the 64-bit port; memory answers on access cycle ready_at (negative: never).
  task automatic run_txn(input logic wr, input logic [1:0] sz, input logic sg, input logic [31:0] addr,
                         input logic [63:0] wd, input logic [63:0] rd, input int ready_at);
    logic legal, got_ready;
    logic [7:0] be;
    logic [63:0] wdx, rdx, erd;
    logic [31:0] maddr;
    logic [1:0] eflt;
    int cyc;
    model(8, sz, sg, addr, wd, rd, legal, be, wdx, rdx, maddr);
    @(negedge clock);
    check_eq("idle_req_ready", req_ready, 1);
    check_eq("idle_rsp_valid", rsp_valid, 0);
    req_valid = 1; req_write = wr; req_size = sz; req_signed = sg; req_addr = addr; req_wdata = wd;
    @(negedge clock);
    req_valid = 0;
    got_ready = 0;
    if (!legal) begin
      check_eq("fault_no_mem_valid", mem_valid, 0);
    end else begin
      cyc = 0;
      while (cyc < TO && !got_ready) begin
        check_eq("acc_mem_valid", mem_valid, 1);
        check_eq("acc_mem_addr", mem_addr, maddr);
        check_eq("acc_mem_be", mem_be, be);
        check_eq("acc_mem_wdata", mem_wdata, wdx);
        check_eq("acc_mem_write", mem_write, wr);
        check_eq("acc_req_ready", req_ready, 0);
        mem_rdata = rd;
        mem_ready = (cyc == ready_at);
        got_ready = mem_ready;
        @(negedge clock);
        mem_ready = 0;
        mem_rdata = {$urandom, $urandom};
        cyc++;
      end
    end
    eflt = !legal ? FLT_ALIGN : (got_ready ? FLT_NONE : FLT_TIMEOUT);
    erd  = (eflt == FLT_NONE && !wr) ? rdx : 64'd0;
    check_eq("rsp_valid", rsp_valid, 1);
    check_eq("rsp_mem_valid", mem_valid, 0);
    check_eq("rsp_req_ready", req_ready, 0);
    check_eq("rsp_fault", rsp_fault, eflt);
    check_eq("rsp_rdata", rsp_rdata, erd);
    last_rdata = rsp_rdata;
    last_fault = rsp_fault;
    if (eflt != FLT_NONE) exp_faults++;
    else if (wr) exp_stores++;
    else exp_loads++;
  endtask

  // One request on the 32-bit port with a zero-wait memory.
  task automatic run32(input logic wr, input logic [1:0] sz, input logic sg, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rd);
    logic legal;
    logic [7:0] be;
    logic [63:0] wdx, rdx;
    logic [31:0] maddr;
    model(4, sz, sg, addr, {32'd0, wd}, {32'd0, rd}, legal, be, wdx, rdx, maddr);
    @(negedge clock);
    check_eq("n_req_ready", req_ready_n, 1);
    req_valid_n = 1; req_write_n = wr; req_size_n = sz; req_signed_n = sg; req_addr_n = addr; req_wdata_n = wd;
    @(negedge clock);
    req_valid_n = 0;
    if (legal) begin
      check_eq("n_mem_valid", mem_valid_n, 1);
      check_eq("n_mem_addr", mem_addr_n, maddr);
      check_eq("n_mem_be", mem_be_n, be & 8'h0F);
      check_eq("n_mem_wdata", mem_wdata_n, wdx);
      mem_ready_n = 1; mem_rdata_n = rd;
      @(negedge clock);
      mem_ready_n = 0;
    end else begin
      check_eq("n_fault_no_mem_valid", mem_valid_n, 0);
    end
    check_eq("n_rsp_valid", rsp_valid_n, 1);
    check_eq("n_rsp_fault", rsp_fault_n, legal ? FLT_NONE : FLT_ALIGN);
    check_eq("n_rsp_rdata", rsp_rdata_n, (legal && !wr) ? rdx : 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    int          nb;
    reset = 0;
    req_valid = 0; req_write = 0; req_size = 0; req_signed = 0; req_addr = 0; req_wdata = 0;
    mem_ready = 0; mem_rdata = 0;
    req_valid_n = 0; req_write_n = 0; req_size_n = 0; req_signed_n = 0; req_addr_n = 0; req_wdata_n = 0;
    mem_ready_n = 0; mem_rdata_n = 0;
    repeat (3) @(negedge clock);
    check_eq("rst_req_ready", req_ready, 1);
    check_eq("rst_mem_valid", mem_valid, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_mem_be", mem_be, 0);
    check_eq("rst_rsp_rdata", rsp_rdata, 0);
    check_eq("rst_rsp_fault", rsp_fault, 0);
    check_eq("rst_req_ready_n", req_ready_n, 1);
    reset = 1;

    run_txn(0, SZ_BYTE, 1, 32'h1003, 64'd0, 64'h0000_0000_8000_0000, 0);
    check_eq("tp_lb_rdata", last_rdata, 64'hFFFF_FFFF_FFFF_FF80);
    run_txn(1, SZ_HALF, 0, 32'h2006, 64'hBEEF, 64'h1234_5678_9ABC_DEF0, 0);
    check_eq("tp_sh_rdata", last_rdata, 64'd0);
    run_txn(0, SZ_WORD, 0, 32'h3002, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    check_eq("tp_misalign_fault", last_fault, FLT_ALIGN);
    run_txn(0, SZ_DOUBLE, 0, 32'h4000, 64'd0, 64'hDEAD_BEEF_0000_0001, -1);
    check_eq("tp_timeout_fault", last_fault, FLT_TIMEOUT);
    run_txn(0, SZ_DOUBLE, 0, 32'h4008, 64'd0, 64'h0123_4567_89AB_CDEF, 0);
    check_eq("tp_after_timeout", last_rdata, 64'h0123_4567_89AB_CDEF);
    run_txn(0, SZ_WORD, 1, 32'h5004, 64'd0, 64'h8765_4321_0000_0000, TO - 1);
    check_eq("tp_last_cycle_fault", last_fault, FLT_NONE);
    check_eq("tp_last_cycle_rdata", last_rdata, 64'hFFFF_FFFF_8765_4321);

    @(negedge clock);
    req_valid = 1; req_write = 0; req_size = SZ_WORD; req_signed = 0; req_addr = 32'h40;
    @(negedge clock);
    req_valid = 0;
    check_eq("rmid_mem_valid_before", mem_valid, 1);
    reset = 0;
    @(negedge clock);
    check_eq("rmid_mem_valid", mem_valid, 0);
    check_eq("rmid_rsp_valid", rsp_valid, 0);
    check_eq("rmid_req_ready", req_ready, 1);
    reset = 1;
    @(negedge clock);
    check_eq("rmid_rsp_after", rsp_valid, 0);
    exp_loads = 0; exp_stores = 0; exp_faults = 0;

    run_txn(0, SZ_HALF, 1, 32'h0102, 64'd0, 64'h0000_0000_F00D_0000, 0);
    run_txn(1, SZ_WORD, 0, 32'h0204, 64'hCAFE_F00D, 64'd0, 1);
    run_txn(0, SZ_BYTE, 0, 32'h0307, 64'd0, 64'h9900_0000_0000_0000, 2);
    run_txn(1, SZ_DOUBLE, 0, 32'h0404, 64'h1, 64'd0, 0);

    for (int k = 0; k < 150; k++) begin
      sz = 2'($urandom_range(0, 3));
      nb = 1 << sz;
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~32'(nb - 1);
      run_txn(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
              {$urandom, $urandom}, {$urandom, $urandom}, int'($urandom_range(0, 5)) - 1);
    end

    run32(0, SZ_DOUBLE, 0, 32'h0000_0000, 32'd0, 32'hFFFF_FFFF);
    run32(0, SZ_WORD, 1, 32'h0000_0004, 32'd0, 32'h8000_0001);
    run32(0, SZ_HALF, 1, 32'h0000_0006, 32'd0, 32'h8001_0000);
    run32(1, SZ_BYTE, 0, 32'h0000_0009, 32'h0000_00A5, 32'd0);
    run32(0, SZ_HALF, 0, 32'h0000_0003, 32'd0, 32'd0);

`ifdef LEGV8_MEM_PORT_STATS_EN
    @(negedge clock);
    check_eq("stat_loads", stat_loads, exp_loads);
    check_eq("stat_stores", stat_stores, exp_stores);
    check_eq("stat_faults", stat_faults, exp_faults);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
